full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 10 +
 rtl/full_adder_if.sv | 28 ++
 rtl/full_adder_fa_cell.sv | 17 +
 rtl/full_adder.sv | 56 +++++
 tb/tb_full_adder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry full adder.
package full_adder_pkg;

  // Operand width used when no WIDTH override is given.
  localparam int unsigned FA_WIDTH_DEFAULT = 1;

  // Bit value loaded into every registered output while rst is high.
  localparam logic FA_RST_VAL = 1'b0;

endpackage : full_adder_pkg

// File: rtl/full_adder_if.sv
// Bundle of the adder's operand and result signals.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             ovf;
  logic [WIDTH-1:0] S_q;
  logic             C_out_q;
  logic             ovf_q;

  // Operand source: drives addends, observes results.
  modport master (
    output A, B, C_in,
    input  S, C_out, ovf, S_q, C_out_q, ovf_q
  );

  // Adder side: consumes addends, produces results.
  modport slave (
    input  A, B, C_in,
    output S, C_out, ovf, S_q, C_out_q, ovf_q
  );

endinterface : full_adder_if

// File: rtl/full_adder_fa_cell.sv
// One-bit full adder cell: the link of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term shared by sum and carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (p & ci);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with combinational results and a
// one-cycle registered copy. The first five ports keep the legacy
// positional order (S, C_out, A, B, C_in) so old instances bind unchanged.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = FA_WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             clk,
  input  logic             rst,
  output logic             ovf,
  output logic [WIDTH-1:0] S_q,
  output logic             C_out_q,
  output logic             ovf_q
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0] carry;

  assign carry[0] = C_in;

  // Ripple chain from bit 0 upward.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (S[i]),
      .co (carry[i+1])
    );
  end

  assign C_out = carry[WIDTH];

  // Signed overflow: carry into the sign bit disagrees with carry out.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

  // Registered copy of the results; synchronous reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_q     <= {WIDTH{FA_RST_VAL}};
      C_out_q <= FA_RST_VAL;
      ovf_q   <= FA_RST_VAL;
    end else begin
      S_q     <= S;
      C_out_q <= C_out;
      ovf_q   <= ovf;
    end
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  logic p_s, p_co, p_ovf, p_sq, p_coq, p_ovfq;

  full_adder #(.WIDTH(1)) u_dut1 (
    .S(bus1.S), .C_out(bus1.C_out), .A(bus1.A), .B(bus1.B), .C_in(bus1.C_in),
    .clk(clk), .rst(rst), .ovf(bus1.ovf), .S_q(bus1.S_q),
    .C_out_q(bus1.C_out_q), .ovf_q(bus1.ovf_q)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .S(bus8.S), .C_out(bus8.C_out), .A(bus8.A), .B(bus8.B), .C_in(bus8.C_in),
    .clk(clk), .rst(rst), .ovf(bus8.ovf), .S_q(bus8.S_q),
    .C_out_q(bus8.C_out_q), .ovf_q(bus8.ovf_q)
  );

  // Legacy positional binding; register held in reset for the whole run.
  full_adder u_pos (p_s, p_co, bus1.A, bus1.B, bus1.C_in, clk, 1'b1,
                    p_ovf, p_sq, p_coq, p_ovfq);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer sum plus sign-rule overflow.
  function automatic exp_t model(input int w, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
    exp_t e;
    logic [8:0] sum;
    logic [7:0] mask;
    mask = 8'((9'd1 << w) - 9'd1);
    sum  = 9'(a & mask) + 9'(b & mask) + 9'(ci);
    e.s  = sum[7:0] & mask;
    e.co = sum[w];
    e.ov = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic drive1(input logic a, input logic b, input logic ci);
    bus1.A = a; bus1.B = b; bus1.C_in = ci;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus8.A = a; bus8.B = b; bus8.C_in = ci;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive1(1'b1, 1'b1, 1'b1);
    drive8(8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1;
    total++;
    if ({bus1.S_q, bus1.C_out_q, bus1.ovf_q} !== 3'b000) begin
      bad++; $display("FAIL reset_w1 got=%b want=000", {bus1.S_q, bus1.C_out_q, bus1.ovf_q});
    end
    total++;
    if ({bus8.S_q, bus8.C_out_q, bus8.ovf_q} !== 10'h000) begin
      bad++; $display("FAIL reset_w8 got=%h want=000", {bus8.S_q, bus8.C_out_q, bus8.ovf_q});
    end
    total++;
    if ({bus1.S, bus1.C_out} !== 2'b11) begin
      bad++; $display("FAIL reset_comb got=%b want=11", {bus1.S, bus1.C_out});
    end
  endtask

  task automatic test_truth_table();
    exp_t e;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(v[2], v[1], v[0]);
      sb.push_back(model(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0]));
      #2;
      e = sb.pop_front();
      total++;
      if ({bus1.S, bus1.C_out, bus1.ovf} !== {e.s[0], e.co, e.ov}) begin
        bad++; $display("FAIL truth_%b got=%b want=%b", v,
                        {bus1.S, bus1.C_out, bus1.ovf}, {e.s[0], e.co, e.ov});
      end
      total++;
      if ({p_s, p_co, p_ovf} !== {e.s[0], e.co, e.ov}) begin
        bad++; $display("FAIL positional_%b got=%b want=%b", v,
                        {p_s, p_co, p_ovf}, {e.s[0], e.co, e.ov});
      end
      #3;
    end
    total++;
    if (p_sq !== 1'b0 || p_coq !== 1'b0 || p_ovfq !== 1'b0) begin
      bad++; $display("FAIL positional_regs got=%b want=000", {p_sq, p_coq, p_ovfq});
    end
  endtask

  task automatic test_width8();
    logic [16:0] vec [8];
    exp_t e;
    vec[0] = {8'hFF, 8'h00, 1'b1};
    vec[1] = {8'h7F, 8'h01, 1'b0};
    vec[2] = {8'h80, 8'h80, 1'b0};
    vec[3] = {8'hFF, 8'hFF, 1'b1};
    vec[4] = {8'h00, 8'h00, 1'b0};
    vec[5] = {8'h55, 8'hAA, 1'b1};
    vec[6] = 17'($urandom);
    vec[7] = 17'($urandom);
    for (int i = 0; i < 8; i++) begin
      drive8(vec[i][16:9], vec[i][8:1], vec[i][0]);
      sb.push_back(model(8, vec[i][16:9], vec[i][8:1], vec[i][0]));
      #1;
      e = sb.pop_front();
      total++;
      if ({bus8.S, bus8.C_out, bus8.ovf} !== {e.s, e.co, e.ov}) begin
        bad++; $display("FAIL w8_vec%0d a=%h b=%h ci=%b got=%h/%b/%b want=%h/%b/%b", i,
                        bus8.A, bus8.B, bus8.C_in, bus8.S, bus8.C_out, bus8.ovf,
                        e.s, e.co, e.ov);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0;
    drive1(1'b1, 1'b1, 1'b1);
    #1;
    total++;
    if ({bus1.S_q, bus1.C_out_q} !== 2'b00) begin
      bad++; $display("FAIL reg_before_edge got=%b want=00", {bus1.S_q, bus1.C_out_q});
    end
    @(posedge clk); #1;
    total++;
    if ({bus1.S_q, bus1.C_out_q, bus1.ovf_q} !== 3'b110) begin
      bad++; $display("FAIL reg_after_edge got=%b want=110", {bus1.S_q, bus1.C_out_q, bus1.ovf_q});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus1.S_q, bus1.C_out_q, bus1.ovf_q} !== 3'b000) begin
      bad++; $display("FAIL midrst_regs got=%b want=000", {bus1.S_q, bus1.C_out_q, bus1.ovf_q});
    end
    total++;
    if ({bus1.S, bus1.C_out} !== 2'b11) begin
      bad++; $display("FAIL midrst_comb got=%b want=11", {bus1.S, bus1.C_out});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus1.S_q, bus1.C_out_q} !== 2'b11) begin
      bad++; $display("FAIL midrst_resume got=%b want=11", {bus1.S_q, bus1.C_out_q});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] a, b;
    logic ci;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      // Decoy value that must not be captured.
      drive8(8'($urandom), 8'($urandom), 1'($urandom));
      #1;
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'h80; ci = 1'b0; end
      drive8(a, b, ci);
      sb.push_back(model(8, a, b, ci));
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        total++; bad++; $display("FAIL b2b_empty got=0 want=1");
      end else begin
        e = sb.pop_front();
        total++;
        if ({bus8.S_q, bus8.C_out_q, bus8.ovf_q} !== {e.s, e.co, e.ov}) begin
          bad++; $display("FAIL b2b_%0d got=%h/%b/%b want=%h/%b/%b", i,
                          bus8.S_q, bus8.C_out_q, bus8.ovf_q, e.s, e.co, e.ov);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive1(1'b0, 1'b0, 1'b0);
    drive8(8'h00, 8'h00, 1'b0);
    test_reset();
    test_truth_table();
    test_width8();
    test_registered();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_full_adder
